timekeeper: RTL and testbench
=============================

# timekeeper

Parametrised multi-digit BCD time counter: the next-generation stopwatch core that sits between the clock-divider/debounce front end and the 7-segment display. It counts NDIG mixed-radix BCD digits (mm:ss pattern by default), up or down, with run/pause toggle, clear, per-digit adjust and a lap-freeze display register. All control inputs are single-cycle strobes or levels already synchronised and debounced upstream.

## Interface
- NDIG, 4, number of BCD digits (2..8); digit 0 is least significant
- HI_MOD, 6, modulus of odd-index digits (even-index digits are modulus 10)
- SELW, 3, width of adj_sel
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-high
- tick  in  1  one-cycle count strobe (1 Hz)
- adj_tick  in  1  one-cycle adjust-load strobe (5 Hz)
- clr  in  1  one-cycle clear strobe
- run_tgl  in  1  one-cycle run/pause toggle strobe
- lap  in  1  one-cycle lap-freeze toggle strobe
- dir  in  1  0 = count up, 1 = count down
- adj  in  1  level; 1 = adjust mode
- adj_sel  in  SELW  digit index to load in adjust mode
- adj_val  in  4  BCD value to load
- digits  out  4*NDIG  live counter value, digit i at [4i+3:4i]
- shown  out  4*NDIG  display value: lap-held snapshot or live
- running  out  1  high in RUN
- lap_active  out  1  high while shown is frozen
- carry  out  1  one-cycle pulse on up-count wrap from all-max to zero
- expired  out  1  one-cycle pulse when a down-count reaches zero

## Operation
- States: IDLE, RUN, PAUSE, ADJUST, EXPIRED.
- Reset: state IDLE, digits 0, shown 0, running 0, lap_active 0, carry 0, expired 0.
- Priority per cycle: clr > adj > run_tgl > tick.
- clr: digits 0, lap_active 0; ADJUST stays ADJUST, every other state goes IDLE.
- adj high in any state -> ADJUST (running drops next cycle). adj low in ADJUST -> PAUSE.
- ADJUST: on adj_tick, digit adj_sel loads adj_val; adj_val >= digit modulus loads modulus-1; adj_sel >= NDIG ignored. tick and run_tgl ignored.
- run_tgl: IDLE/PAUSE -> RUN; RUN -> PAUSE; ignored in EXPIRED. In IDLE with dir=1 and digits all zero: ignored.
- tick counts only if the current (pre-transition) state is RUN.
- Up: increment digit 0, ripple carry; digit at modulus-1 wraps to 0. All digits at max wrap to all-zero, carry pulses, state stays RUN.
- Down: decrement with ripple borrow; a digit at 0 borrows to modulus-1. Transition to all-zero: state EXPIRED, expired pulses, digits hold 0.
- dir sampled every tick; changing it mid-run is legal.
- lap: in RUN or PAUSE with lap_active 0, snapshot digits into shown and set lap_active; with lap_active 1 (any state), clear it. Otherwise shown tracks digits.

## Timing
- All outputs registered. digits/shown update the cycle after the strobe.
- carry/expired assert the cycle after the causing tick, exactly one cycle.
- Snapshot captures digits as of the lap cycle (pre-tick value if tick coincides).
- rst mid-operation: immediate return to reset values regardless of state.

## Configuration
- TIMEKEEPER_COUNTDOWN_EN defined: dir functional, EXPIRED state and expired output as above.
- Undefined: dir ignored (always up), EXPIRED state absent, expired tied 0; IDLE run_tgl zero-check removed.

## Structure
- Package timekeeper_pkg: state enum, BCD digit width (4), default moduli (10, 6).
- Sub-module bcd_digit: one digit with modulus parameter, inc/dec/load/clear, carry/borrow in and out, is-max/is-zero flags; instantiated NDIG times in a chain.

## Test plan
- Reset, run_tgl, 60 ticks up -> digits 01:00, running 1; then run_tgl -> PAUSE, further ticks leave 01:00.
- Preload 59:59 via ADJUST, exit, run, 1 tick -> 00:00 with one-cycle carry.
- Countdown (macro on): adjust to 00:02, dir=1, run, 2 ticks -> 00:00, expired pulse once, state EXPIRED, run_tgl ignored, clr -> IDLE.
- ADJUST: adj_sel=1, adj_val=9, adj_tick -> digit 1 = 5; adj_sel=5 -> no change; tick ignored.
- Lap at 00:07 while running, 3 ticks -> shown 00:07, digits 00:10; lap again -> shown 00:10.
- clr, run_tgl and tick in same cycle while RUN at 00:05 -> digits 00:00, state IDLE, lap_active 0.

Source files
------------

// File: rtl/timekeeper_pkg.sv
// Shared types and constants for the timekeeper stopwatch core.
// The EXPIRED state exists only when TIMEKEEPER_COUNTDOWN_EN is defined.
package timekeeper_pkg;

   localparam int DIGIT_W = 4;
   localparam int MOD_LO  = 10;
   localparam int MOD_HI  = 6;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_RUN    = 3'd1,
      ST_PAUSE  = 3'd2,
      ST_ADJUST = 3'd3
`ifdef TIMEKEEPER_COUNTDOWN_EN
      ,
      ST_EXPIRED = 3'd4
`endif
   } state_e;

   // Odd-index digits use the high modulus (tens of seconds/minutes).
   function automatic int digit_mod(input int idx, input int hi_mod);
      return ((idx % 2) == 1) ? hi_mod : MOD_LO;
   endfunction

endpackage

// File: rtl/timekeeper_if.sv
// Control strobes and display outputs of the timekeeper core.
interface timekeeper_if #(
   parameter int NDIG = 4,
   parameter int SELW = 3
);
   logic                  tick;
   logic                  adj_tick;
   logic                  clr;
   logic                  run_tgl;
   logic                  lap;
   logic                  dir;
   logic                  adj;
   logic [SELW-1:0]       adj_sel;
   logic [3:0]            adj_val;
   logic [4*NDIG-1:0]     digits;
   logic [4*NDIG-1:0]     shown;
   logic                  running;
   logic                  lap_active;
   logic                  carry;
   logic                  expired;

   modport master (
      output tick, adj_tick, clr, run_tgl, lap, dir, adj, adj_sel, adj_val,
      input  digits, shown, running, lap_active, carry, expired
   );

   modport slave (
      input  tick, adj_tick, clr, run_tgl, lap, dir, adj, adj_sel, adj_val,
      output digits, shown, running, lap_active, carry, expired
   );
endinterface

// File: rtl/timekeeper_bcd_digit.sv
// One BCD digit of modulus MOD with step, clamped load and clear; cout ripples
// the carry (up) or borrow (down) into the next digit.
module bcd_digit
   import timekeeper_pkg::*;
#(
   parameter int MOD = MOD_LO
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               inc,
   input  logic               dec,
   input  logic               cin,
   input  logic               load,
   input  logic [DIGIT_W-1:0] load_val,
   input  logic               clr,
   output logic [DIGIT_W-1:0] value,
   output logic [DIGIT_W-1:0] nxt,
   output logic               is_max,
   output logic               is_zero,
   output logic               cout
);
   localparam logic [DIGIT_W-1:0] MAXV = DIGIT_W'(MOD - 1);

   logic [DIGIT_W-1:0] value_q, value_d;

   assign is_max  = (value_q == MAXV);
   assign is_zero = (value_q == {DIGIT_W{1'b0}});
   assign cout    = cin & ((inc & is_max) | (dec & is_zero));
   assign value   = value_q;
   assign nxt     = value_d;

   // Next digit value: clear beats load beats step.
   always_comb begin
      value_d = value_q;
      if (clr) begin
         value_d = {DIGIT_W{1'b0}};
      end else if (load) begin
         value_d = (load_val > MAXV) ? MAXV : load_val;
      end else if (cin && inc) begin
         value_d = is_max ? {DIGIT_W{1'b0}} : value_q + {{(DIGIT_W-1){1'b0}}, 1'b1};
      end else if (cin && dec) begin
         value_d = is_zero ? MAXV : value_q - {{(DIGIT_W-1){1'b0}}, 1'b1};
      end else begin
         value_d = value_q;
      end
   end

   // Digit register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value_q <= {DIGIT_W{1'b0}};
      end else begin
         value_q <= value_d;
      end
   end
endmodule

// File: rtl/timekeeper.sv
// timekeeper: NDIG-digit mixed-radix BCD stopwatch with run/pause, adjust and lap freeze.
// Countdown (dir, EXPIRED state, expired pulse) is built only with TIMEKEEPER_COUNTDOWN_EN.
module timekeeper
   import timekeeper_pkg::*;
#(
   parameter int NDIG   = 4,
   parameter int HI_MOD = MOD_HI,
   parameter int SELW   = 3
) (
   input  logic        clk,
   input  logic        rst,
   timekeeper_if.slave bus
);
   localparam int W = DIGIT_W * NDIG;

   state_e          state_q, state_d;
   logic            lap_q, lap_d;
   logic            running_q, running_d;
   logic            carry_q, carry_d;
   logic [W-1:0]    shown_q, shown_d;
   logic [W-1:0]    digits_s, digits_nxt_s;
   logic            inc_s, dec_s, load_s, clear_s;
   logic            count_down_s, zero_block_s;
   logic            all_max_s, all_zero_s, one_s;
   logic [NDIG:0]   cin_s;
   logic [NDIG-1:0] is_max_s, is_zero_s, sel_s;
   logic            unused_s;
`ifdef TIMEKEEPER_COUNTDOWN_EN
   logic            expired_q, expired_d;
`endif

   assign cin_s[0] = 1'b1;

   for (genvar gi = 0; gi < NDIG; gi++) begin : g_dig
      assign sel_s[gi] = load_s && (int'(bus.adj_sel) == gi);
      bcd_digit #(.MOD(digit_mod(gi, HI_MOD))) u_dig (
         .clk      (clk),
         .rst      (rst),
         .inc      (inc_s),
         .dec      (dec_s),
         .cin      (cin_s[gi]),
         .load     (sel_s[gi]),
         .load_val (bus.adj_val),
         .clr      (clear_s),
         .value    (digits_s[DIGIT_W*gi +: DIGIT_W]),
         .nxt      (digits_nxt_s[DIGIT_W*gi +: DIGIT_W]),
         .is_max   (is_max_s[gi]),
         .is_zero  (is_zero_s[gi]),
         .cout     (cin_s[gi+1])
      );
   end

   assign all_max_s  = &is_max_s;
   assign all_zero_s = &is_zero_s;
   assign one_s      = (digits_s[DIGIT_W-1:0] == 4'd1) && (&is_zero_s[NDIG-1:1]);

`ifdef TIMEKEEPER_COUNTDOWN_EN
   assign count_down_s = bus.dir;
   assign zero_block_s = bus.dir & all_zero_s;
   assign unused_s     = cin_s[NDIG];
   assign bus.expired  = expired_q;
`else
   assign count_down_s = 1'b0;
   assign zero_block_s = 1'b0;
   assign unused_s     = ^{cin_s[NDIG], bus.dir, one_s, all_zero_s};
   assign bus.expired  = 1'b0;
`endif

   // Control FSM: one action per cycle, in the order clr, adj, run_tgl, tick.
   always_comb begin
      state_d = state_q;
      carry_d = 1'b0;
      inc_s   = 1'b0;
      dec_s   = 1'b0;
      load_s  = 1'b0;
      clear_s = 1'b0;
`ifdef TIMEKEEPER_COUNTDOWN_EN
      expired_d = 1'b0;
`endif
      if (bus.clr) begin
         clear_s = 1'b1;
         state_d = (state_q == ST_ADJUST) ? ST_ADJUST : ST_IDLE;
      end else if (bus.adj) begin
         state_d = ST_ADJUST;
         load_s  = (state_q == ST_ADJUST) && bus.adj_tick;
      end else if (state_q == ST_ADJUST) begin
         state_d = ST_PAUSE;
      end else if (bus.run_tgl) begin
         case (state_q)
            ST_IDLE:  state_d = zero_block_s ? ST_IDLE : ST_RUN;
            ST_RUN:   state_d = ST_PAUSE;
            ST_PAUSE: state_d = ST_RUN;
            default:  state_d = state_q;
         endcase
      end else if (bus.tick && (state_q == ST_RUN)) begin
         if (count_down_s) begin
            dec_s = 1'b1;
`ifdef TIMEKEEPER_COUNTDOWN_EN
            if (one_s) begin
               state_d   = ST_EXPIRED;
               expired_d = 1'b1;
            end else begin
               state_d = state_q;
            end
`endif
         end else begin
            inc_s   = 1'b1;
            carry_d = all_max_s;
         end
      end else begin
         state_d = state_q;
      end
   end

   // Lap freeze: snapshot the pre-update digits, otherwise follow the next value.
   always_comb begin
      lap_d = lap_q;
      if (bus.clr) begin
         lap_d = 1'b0;
      end else if (bus.lap) begin
         if (lap_q) begin
            lap_d = 1'b0;
         end else if ((state_q == ST_RUN) || (state_q == ST_PAUSE)) begin
            lap_d = 1'b1;
         end else begin
            lap_d = lap_q;
         end
      end else begin
         lap_d = lap_q;
      end
      if (lap_d && !lap_q) begin
         shown_d = digits_s;
      end else if (lap_d) begin
         shown_d = shown_q;
      end else begin
         shown_d = digits_nxt_s;
      end
      running_d = (state_d == ST_RUN);
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         lap_q     <= 1'b0;
         running_q <= 1'b0;
         carry_q   <= 1'b0;
         shown_q   <= {W{1'b0}};
`ifdef TIMEKEEPER_COUNTDOWN_EN
         expired_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         lap_q     <= lap_d;
         running_q <= running_d;
         carry_q   <= carry_d;
         shown_q   <= shown_d;
`ifdef TIMEKEEPER_COUNTDOWN_EN
         expired_q <= expired_d;
`endif
      end
   end

   assign bus.digits     = digits_s;
   assign bus.shown      = shown_q;
   assign bus.running    = running_q;
   assign bus.lap_active = lap_q;
   assign bus.carry      = carry_q;
endmodule

// File: tb/tb_timekeeper.sv
// Self-checking bench for timekeeper: directed scenarios plus random strobes
// against a model that keeps the time as a single integer count.
module tb_timekeeper;
   localparam int NDIG   = 4;
   localparam int HI_MOD = 6;
   localparam int SELW   = 3;
   localparam int W      = 4 * NDIG;
`ifdef TIMEKEEPER_COUNTDOWN_EN
   localparam bit CD = 1'b1;
`else
   localparam bit CD = 1'b0;
`endif
   localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_ADJ = 3, S_EXP = 4;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   int m_state, m_n, m_snap;
   bit m_lap, m_carry, m_exp;

   timekeeper_if #(.NDIG(NDIG), .SELW(SELW)) bus ();

   timekeeper #(.NDIG(NDIG), .HI_MOD(HI_MOD), .SELW(SELW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   function automatic int dmod(input int i);
      return ((i % 2) == 1) ? HI_MOD : 10;
   endfunction

   function automatic int total();
      int t = 1;
      for (int i = 0; i < NDIG; i++) t = t * dmod(i);
      return t;
   endfunction

   function automatic logic [W-1:0] to_bus(input int n);
      logic [W-1:0] b = '0;
      int r = n;
      for (int i = 0; i < NDIG; i++) begin
         b[4*i +: 4] = 4'(r % dmod(i));
         r = r / dmod(i);
      end
      return b;
   endfunction

   function automatic int set_digit(input int n, input int sel, input int val);
      int w = 1;
      int d, v;
      for (int i = 0; i < sel; i++) w = w * dmod(i);
      d = (n / w) % dmod(sel);
      v = (val > dmod(sel) - 1) ? dmod(sel) - 1 : val;
      return n + (v - d) * w;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_state = S_IDLE; m_n = 0; m_snap = 0;
      m_lap = 1'b0; m_carry = 1'b0; m_exp = 1'b0;
   endtask

   task automatic model_step();
      int  ns, nn, nsnap;
      bit  nlap;
      ns = m_state; nn = m_n; nsnap = m_snap; nlap = m_lap;
      m_carry = 1'b0; m_exp = 1'b0;
      if (bus.clr) begin
         nn = 0;
         ns = (m_state == S_ADJ) ? S_ADJ : S_IDLE;
      end else if (bus.adj) begin
         ns = S_ADJ;
         if (m_state == S_ADJ && bus.adj_tick && int'(bus.adj_sel) < NDIG)
            nn = set_digit(m_n, int'(bus.adj_sel), int'(bus.adj_val));
      end else if (m_state == S_ADJ) begin
         ns = S_PAUSE;
      end else if (bus.run_tgl) begin
         if (m_state == S_RUN) ns = S_PAUSE;
         else if (m_state == S_PAUSE) ns = S_RUN;
         else if (m_state == S_IDLE && !(CD && bus.dir && m_n == 0)) ns = S_RUN;
      end else if (bus.tick && m_state == S_RUN) begin
         if (CD && bus.dir) begin
            nn = (m_n + total() - 1) % total();
            if (nn == 0) begin ns = S_EXP; m_exp = 1'b1; end
         end else begin
            if (m_n == total() - 1) m_carry = 1'b1;
            nn = (m_n + 1) % total();
         end
      end
      if (bus.clr) nlap = 1'b0;
      else if (bus.lap) begin
         if (m_lap) nlap = 1'b0;
         else if (m_state == S_RUN || m_state == S_PAUSE) begin
            nlap = 1'b1; nsnap = m_n;
         end
      end
      m_state = ns; m_n = nn; m_lap = nlap; m_snap = nsnap;
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
      chk("digits", bus.digits, to_bus(m_n));
      chk("shown", bus.shown, m_lap ? to_bus(m_snap) : to_bus(m_n));
      chk("running", bus.running, m_state == S_RUN);
      chk("lap_active", bus.lap_active, m_lap);
      chk("carry", bus.carry, m_carry);
      chk("expired", bus.expired, m_exp);
      bus.tick = 1'b0; bus.adj_tick = 1'b0; bus.clr = 1'b0;
      bus.run_tgl = 1'b0; bus.lap = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         bus.tick = 1'b1;
         cycle();
      end
   endtask

   task automatic adj_load(input int sel, input int val);
      bus.adj_sel = SELW'(sel); bus.adj_val = 4'(val); bus.adj_tick = 1'b1;
      cycle();
   endtask

   initial begin
      rst = 1'b1;
      bus.tick = 1'b0; bus.adj_tick = 1'b0; bus.clr = 1'b0; bus.run_tgl = 1'b0;
      bus.lap = 1'b0; bus.dir = 1'b0; bus.adj = 1'b0;
      bus.adj_sel = '0; bus.adj_val = 4'd0;
      model_reset();
      #12;
      chk("rst_digits", bus.digits, 0);
      chk("rst_shown", bus.shown, 0);
      chk("rst_running", bus.running, 0);
      chk("rst_lap", bus.lap_active, 0);
      chk("rst_carry", bus.carry, 0);
      chk("rst_expired", bus.expired, 0);
      rst = 1'b0;

      // Count up 60 s, then pause.
      bus.run_tgl = 1'b1; cycle();
      ticks(60);
      chk("up60_digits", bus.digits, 16'h0100);
      chk("up60_running", bus.running, 1);
      bus.run_tgl = 1'b1; cycle();
      ticks(5);
      chk("pause_digits", bus.digits, 16'h0100);
      chk("pause_running", bus.running, 0);

      // Adjust: clamp, out-of-range select, tick ignored, preload 59:59.
      bus.adj = 1'b1; cycle();
      adj_load(1, 9);
      chk("adj_clamp", bus.digits, 16'h0150);
      adj_load(5, 3);
      chk("adj_badsel", bus.digits, 16'h0150);
      ticks(1);
      chk("adj_tick_ign", bus.digits, 16'h0150);
      for (int s = 0; s < NDIG; s++) adj_load(s, 9);
      chk("adj_5959", bus.digits, 16'h5959);
      bus.adj = 1'b0; cycle();
      bus.run_tgl = 1'b1; cycle();
      ticks(1);
      chk("wrap_digits", bus.digits, 16'h0000);
      chk("wrap_carry", bus.carry, 1);
      cycle();
      chk("carry_once", bus.carry, 0);

      // Lap freeze while running.
      ticks(7);
      bus.lap = 1'b1; cycle();
      chk("lap_on", bus.lap_active, 1);
      ticks(3);
      chk("lap_shown", bus.shown, 16'h0007);
      chk("lap_digits", bus.digits, 16'h0010);
      bus.lap = 1'b1; cycle();
      chk("lap_off_shown", bus.shown, 16'h0010);

      // clr + run_tgl + tick together while running with lap held.
      bus.clr = 1'b1; cycle();
      bus.run_tgl = 1'b1; cycle();
      ticks(5);
      bus.lap = 1'b1; cycle();
      bus.clr = 1'b1; bus.run_tgl = 1'b1; bus.tick = 1'b1; cycle();
      chk("clr_digits", bus.digits, 16'h0000);
      chk("clr_running", bus.running, 0);
      chk("clr_lap", bus.lap_active, 0);

`ifdef TIMEKEEPER_COUNTDOWN_EN
      bus.dir = 1'b1;
      bus.run_tgl = 1'b1; cycle();
      chk("zero_block", bus.running, 0);
      bus.adj = 1'b1; cycle();
      adj_load(0, 2);
      bus.adj = 1'b0; cycle();
      bus.run_tgl = 1'b1; cycle();
      ticks(1);
      chk("cd_one", bus.digits, 16'h0001);
      ticks(1);
      chk("cd_zero", bus.digits, 16'h0000);
      chk("cd_expired", bus.expired, 1);
      cycle();
      chk("cd_exp_once", bus.expired, 0);
      bus.run_tgl = 1'b1; cycle();
      chk("exp_tgl_ign", bus.running, 0);
      bus.clr = 1'b1; cycle();
      bus.dir = 1'b0;
      bus.run_tgl = 1'b1; cycle();
      chk("exp_clr_idle", bus.running, 1);
      bus.clr = 1'b1; cycle();
`endif

      // Asynchronous reset in the middle of a run.
      bus.run_tgl = 1'b1; cycle();
      ticks(3);
      bus.lap = 1'b1; cycle();
      #2 rst = 1'b1;
      model_reset();
      #1;
      chk("mid_rst_digits", bus.digits, 0);
      chk("mid_rst_shown", bus.shown, 0);
      chk("mid_rst_running", bus.running, 0);
      chk("mid_rst_lap", bus.lap_active, 0);
      @(negedge clk);
      rst = 1'b0;

      // Random strobes.
      for (int k = 0; k < 1500; k++) begin
         bus.tick     = ($urandom_range(2, 0) == 0);
         bus.adj_tick = ($urandom_range(3, 0) == 0);
         bus.clr      = ($urandom_range(63, 0) == 0);
         bus.run_tgl  = ($urandom_range(15, 0) == 0);
         bus.lap      = ($urandom_range(19, 0) == 0);
         if ($urandom_range(49, 0) == 0) bus.dir = ~bus.dir;
         if (bus.adj) begin
            if ($urandom_range(7, 0) == 0) bus.adj = 1'b0;
         end else begin
            if ($urandom_range(59, 0) == 0) bus.adj = 1'b1;
         end
         bus.adj_sel = SELW'($urandom_range(7, 0));
         bus.adj_val = 4'($urandom_range(15, 0));
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
